svc_rv_wb_arb: RTL and testbench

- Owns the single register-file write port.
- Shares that port between the in-order pipeline WB result, which has priority, and a multi-cycle execution unit (divider/long-latency ops) that completes out of order relative to the pipeline.
- Keeps a destination scoreboard of outstanding multi-cycle ops so ID can stall on RAW hazards.
- Raises a drain request when the multi-cycle unit is starved, so the hazard unit injects bubbles.

---
 rtl/svc_rv_wb_arb_pkg.sv | 18 +
 rtl/svc_rv_wb_scoreboard.sv | 86 ++++++++
 rtl/svc_rv_wb_arb.sv | 96 +++++++++
 tb/tb_svc_rv_wb_arb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_wb_arb_pkg.sv
// rtl/svc_rv_wb_arb_pkg.sv - shared constants and types for the write-back arbiter
package svc_rv_wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Which producer owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_PIPE = 2'd1,
        WB_SRC_MC   = 2'd2
    } wb_src_e;

    function automatic logic rd_is_x0(input logic [REG_ADDR_W-1:0] rd);
        return rd == '0;
    endfunction

endpackage

// File: rtl/svc_rv_wb_scoreboard.sv
// rtl/svc_rv_wb_scoreboard.sv - busy bitmap, in-order rd FIFO and RAW hazard detect
module svc_rv_wb_scoreboard
    import svc_rv_wb_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    output logic                  issue_ready_o,
    input  logic                  mc_hs_i,
    input  logic [REG_ADDR_W-1:0] mc_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  hazard_o,
    output logic                  empty_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [REG_ADDR_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic                  push, pop;

    assign issue_ready_o = rst_ni && !busy_q[issue_rd_i] && (cnt_q < CNT_MAX);
    assign push          = issue_valid_i && issue_ready_o;
    // A result with nothing outstanding is still consumed, it just never touches the FIFO.
    assign pop           = mc_hs_i && (cnt_q != '0);
    assign empty_o       = (cnt_q == '0);
    assign hazard_o      = (!rd_is_x0(rs1_i) && busy_q[rs1_i]) ||
                           (!rd_is_x0(rs2_i) && busy_q[rs2_i]);

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (mc_hs_i && !rd_is_x0(mc_rd_i)) begin
            busy_d[mc_rd_i] = 1'b0;
        end
        if (push && !rd_is_x0(issue_rd_i)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= issue_rd_i;
        end
    end

    // The multi-cycle unit must retire in issue order.
    assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> (fifo_q[rd_ptr_q] == mc_rd_i));

endmodule

// File: rtl/svc_rv_wb_arb.sv
// rtl/svc_rv_wb_arb.sv - register-file write-port arbiter between pipeline WB and multi-cycle unit
module svc_rv_wb_arb
    import svc_rv_wb_arb_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_WAIT        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_rd,
    input  logic [XLEN-1:0]       mc_data,
    output logic                  mc_ready,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    output logic                  hazard_id,
    output logic                  drain_req,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_data,
    output logic                  idle
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    wb_src_e           src;
    logic              mc_hs;
    logic              sb_empty;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              drain_q, drain_d;

    // Pipeline always wins; the multi-cycle unit only gets the port on pipeline bubbles.
    always_comb begin
        src     = WB_SRC_NONE;
        rf_rd   = '0;
        rf_data = '0;
        if (pipe_we) begin
            src     = WB_SRC_PIPE;
            rf_rd   = pipe_rd;
            rf_data = pipe_data;
        end else if (mc_valid) begin
            src     = WB_SRC_MC;
            rf_rd   = mc_rd;
            rf_data = mc_data;
        end
    end

    assign rf_we     = rst_n && (src != WB_SRC_NONE) && !rd_is_x0(rf_rd);
    assign mc_ready  = rst_n && !pipe_we;
    assign mc_hs     = mc_valid && mc_ready;
    assign drain_req = drain_q;
    assign idle      = sb_empty && !mc_valid;

    always_comb begin
        wait_cnt_d = '0;
        if (mc_valid && !mc_ready) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        drain_d = (wait_cnt_d == WAIT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            drain_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            drain_q    <= drain_d;
        end
    end

    svc_rv_wb_scoreboard #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_sb (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .issue_valid_i(issue_valid),
        .issue_rd_i   (issue_rd),
        .issue_ready_o(issue_ready),
        .mc_hs_i      (mc_hs),
        .mc_rd_i      (mc_rd),
        .rs1_i        (rs1_id),
        .rs2_i        (rs2_id),
        .hazard_o     (hazard_id),
        .empty_o      (sb_empty)
    );

endmodule

// File: tb/tb_svc_rv_wb_arb.sv
// tb/tb_svc_rv_wb_arb.sv - scoreboard bench for the write-back arbiter
module tb_svc_rv_wb_arb;

    localparam int XLEN = 32;
    localparam logic [7:0] M_WE = 8'h01, M_RD = 8'h02, M_DATA = 8'h04, M_MR = 8'h08,
                           M_IR = 8'h10, M_HZ = 8'h20, M_DR = 8'h40, M_IDL = 8'h80;
    localparam logic [7:0] M_WR = M_WE | M_RD | M_DATA | M_MR;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pipe_we, issue_valid, mc_valid;
    logic [4:0]      pipe_rd, issue_rd, mc_rd, rs1_id, rs2_id;
    logic [XLEN-1:0] pipe_data, mc_data;
    logic            issue_ready, mc_ready, hazard_id, drain_req, rf_we, idle;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_data;

    always #5 clk = ~clk;

    svc_rv_wb_arb #(.XLEN(XLEN), .MAX_OUTSTANDING(2), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .hazard_id(hazard_id), .drain_req(drain_req),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .idle(idle)
    );

    typedef struct {
        string      name;
        logic [7:0] mask;
        logic       we;
        logic [4:0] rd;
        logic [31:0] data;
        logic       mr, ir, hz, dr, idl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_out(input string n, input logic [7:0] m, input logic we,
                              input logic [4:0] rd, input logic [31:0] d, input logic mr,
                              input logic ir, input logic hz, input logic dr, input logic idl);
        exp_t e;
        e.name = n; e.mask = m; e.we = we; e.rd = rd; e.data = d;
        e.mr = mr; e.ir = ir; e.hz = hz; e.dr = dr; e.idl = idl;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", n, f, act, exp);
        end
    endtask

    // Monitor: each negedge, compare every expectation queued for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.mask[0]) chk(e.name, "rf_we",       32'(rf_we),       32'(e.we));
                if (e.mask[1]) chk(e.name, "rf_rd",       32'(rf_rd),       32'(e.rd));
                if (e.mask[2]) chk(e.name, "rf_data",     rf_data,          e.data);
                if (e.mask[3]) chk(e.name, "mc_ready",    32'(mc_ready),    32'(e.mr));
                if (e.mask[4]) chk(e.name, "issue_ready", 32'(issue_ready), 32'(e.ir));
                if (e.mask[5]) chk(e.name, "hazard_id",   32'(hazard_id),   32'(e.hz));
                if (e.mask[6]) chk(e.name, "drain_req",   32'(drain_req),   32'(e.dr));
                if (e.mask[7]) chk(e.name, "idle",        32'(idle),        32'(e.idl));
            end
        end
    end

    task automatic clr();
        pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        issue_valid = 0; issue_rd = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
        rs1_id = 0; rs2_id = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic mc(input logic [4:0] rd, input logic [31:0] d);
        mc_valid = 1; mc_rd = rd; mc_data = d;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
        pipe_we = 1; pipe_rd = rd; pipe_data = d;
    endtask

    task automatic iss(input logic [4:0] rd);
        issue_valid = 1; issue_rd = rd;
    endtask

    initial begin
        rst_n = 0;
        clr();
        expect_out("in_reset", M_WE | M_MR | M_IR | M_DR | M_IDL, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        cyc(); expect_out("post_reset", M_WE | M_MR | M_IR | M_HZ | M_DR | M_IDL, 0, 0, 0, 1, 1, 0, 0, 1);
        cyc(); mc(5, 32'hDEAD_0005);
        expect_out("mc_only", M_WR | M_DR | M_IDL, 1, 5, 32'hDEAD_0005, 1, 0, 0, 0, 0);

        // RAW hazard on an outstanding rd, no bypass in the completion cycle
        cyc(); iss(7); rs1_id = 7; expect_out("issue7", M_IR | M_HZ | M_IDL, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc(); rs1_id = 7;         expect_out("haz7_set", M_IR | M_HZ | M_IDL, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(); rs1_id = 7; mc(7, 32'h0000_0777);
        expect_out("complete7", M_WR | M_HZ, 1, 7, 32'h0000_0777, 1, 0, 1, 0, 0);
        cyc(); rs1_id = 7;         expect_out("haz7_clear", M_HZ | M_IDL, 0, 0, 0, 0, 0, 0, 0, 1);

        // Starvation: drain_req rises after four denied cycles
        for (int i = 0; i < 6; i++) begin
            cyc(); pipe(10, 32'h0000_000A); mc(12, 32'h0000_000C);
            expect_out($sformatf("starve%0d", i), M_WR | M_DR | M_IDL, 1, 10, 32'h0000_000A, 0, 0, 0, (i >= 4), 0);
        end
        cyc(); mc(12, 32'h0000_000C);
        expect_out("drain_hs", M_WR | M_DR, 1, 12, 32'h0000_000C, 1, 0, 0, 1, 0);
        // Counter must restart from zero after the handshake
        for (int i = 0; i < 4; i++) begin
            cyc(); pipe(10, 32'h0000_000A); mc(12, 32'h0000_000C);
            expect_out($sformatf("restarve%0d", i), M_MR | M_DR, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        cyc(); expect_out("restarve_hit", M_DR, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(); expect_out("restarve_clr", M_DR | M_IDL, 0, 0, 0, 0, 0, 0, 0, 1);

        // Outstanding limit, WAW block, simultaneous issue and completion
        cyc(); iss(3);             expect_out("issue3", M_IR | M_IDL, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc(); issue_rd = 3;       expect_out("waw3", M_IR | M_IDL, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(); mc(3, 32'h0000_0033); iss(4); rs1_id = 3;
        expect_out("cmp3_iss4", M_WR | M_IR | M_HZ, 1, 3, 32'h0000_0033, 1, 1, 1, 0, 0);
        cyc(); iss(9); rs1_id = 3; expect_out("issue9", M_IR | M_HZ, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(); iss(11); rs1_id = 4; rs2_id = 9;
        expect_out("full11", M_IR | M_HZ, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(); iss(4); rs2_id = 9; expect_out("busy4", M_IR | M_HZ, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc();                     expect_out("x0_src", M_HZ | M_IDL, 0, 0, 0, 0, 0, 0, 0, 0);

        // x0 handling
        cyc(); mc(4, 32'h0000_0044); rs1_id = 4;
        expect_out("cmp4", M_WR | M_HZ, 1, 4, 32'h0000_0044, 1, 0, 1, 0, 0);
        cyc(); iss(0); rs1_id = 4; expect_out("issue_x0", M_IR | M_HZ, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(); iss(11);            expect_out("full_x0", M_IR | M_IDL, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(); mc(9, 32'h0000_0099);
        expect_out("cmp9", M_WR, 1, 9, 32'h0000_0099, 1, 0, 0, 0, 0);
        cyc(); mc(0, 32'h0000_BAD0); expect_out("cmp_x0", M_WE | M_MR | M_IDL, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc();                       expect_out("drained", M_IR | M_IDL, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc(); pipe(0, 32'h0000_BAD1); mc(6, 32'h0000_0066);
        expect_out("pipe_x0", M_WE | M_MR | M_IDL, 0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset with state outstanding
        cyc(); iss(13); expect_out("issue13", M_IR, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(); iss(14); expect_out("issue14", M_IR, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(); pipe(1, 32'h0000_0011); mc(13, 32'h0000_000D); rs1_id = 13;
            expect_out($sformatf("pre_rst%0d", i), M_WR | M_IR | M_HZ | M_DR, 1, 1, 32'h0000_0011, 0, 0, 1, (i == 4), 0);
        end
        cyc(); rst_n = 0; rs1_id = 13; issue_rd = 13;
        expect_out("async_rst", M_WE | M_MR | M_IR | M_HZ | M_DR | M_IDL, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(); rst_n = 1; rs1_id = 13; issue_rd = 13;
        expect_out("after_rst", M_IR | M_HZ | M_DR | M_IDL, 0, 0, 0, 0, 1, 0, 0, 1);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL monitor_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
